// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seg7_scan_ctrl_pkg;

  // Scan FSM encoding kept as plain constants so older tools can consume it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_DRIVE = 2'd2;

  // Off values in the internal active-high domain; polarity is applied at the
  // output registers only.
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic       DIG_OFF = 1'b0;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side bundle of the scan controller: digit data in, display lines out.
// Latency: n/a (wiring only).
// Backpressure: none; load is a single-cycle strobe that is always accepted.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   din;
  logic [NUM_DIGITS-1:0]     dot_in;
  logic                      blank_lz;
  logic [7:0]                seg_out;
  logic [NUM_DIGITS-1:0]     dig_sel;
  logic                      frame_start;

  // Host drives data and control, observes the display lines.
  modport master (
    output enable, load, din, dot_in, blank_lz,
    input  seg_out, dig_sel, frame_start
  );

  // Controller consumes data and control, drives the display lines.
  modport slave (
    input  enable, load, din, dot_in, blank_lz,
    output seg_out, dig_sel, frame_start
  );

endinterface

// File: rtl/seg7_scan_ctrl_sevendec.sv
// Hex nibble to 7-segment code, active-high, bit0=a .. bit6=g, bit7=dot.
// Latency: combinational.
// Backpressure: none.
module seg7_scan_ctrl_sevendec (
  input  logic [3:0] nib_i,
  input  logic       dot_i,
  output logic [7:0] seg_o
);

  logic [6:0] seg_code;

  // Segment lookup for 0-9 and A, b, C, d, E, F.
  always_comb begin
    seg_code = 7'h00;
    case (nib_i)
      4'h0: seg_code = 7'h3F;
      4'h1: seg_code = 7'h06;
      4'h2: seg_code = 7'h5B;
      4'h3: seg_code = 7'h4F;
      4'h4: seg_code = 7'h66;
      4'h5: seg_code = 7'h6D;
      4'h6: seg_code = 7'h7D;
      4'h7: seg_code = 7'h07;
      4'h8: seg_code = 7'h7F;
      4'h9: seg_code = 7'h6F;
      4'hA: seg_code = 7'h77;
      4'hB: seg_code = 7'h7C;
      4'hC: seg_code = 7'h39;
      4'hD: seg_code = 7'h5E;
      4'hE: seg_code = 7'h79;
      4'hF: seg_code = 7'h71;
      default: seg_code = 7'h00;
    endcase
  end

  assign seg_o = {dot_i, seg_code};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scanner with double-buffered digit data.
// Latency: display lines follow the scan state by one clock; loads show at the next frame start.
// Backpressure: none; load strobes are always accepted, enable=0 stops scanning next cycle.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,     // >= 2
  parameter int SCAN_DIV       = 1000,  // clocks per digit slot, >= 2
  parameter int BLANK_CYC      = 16,    // all-off clocks at slot start, 0..SCAN_DIV-1
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst_x,
  seg7_scan_ctrl_if.slave bus
);

  localparam int PW = clog2(SCAN_DIV);
  localparam int IW = clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  // With no blanking gap the BLANK state is never entered, so its end value is unused.
  localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Every slot begins in BLANK unless the gap is disabled.
  localparam state_t SLOT_START = (BLANK_CYC > 0) ? ST_BLANK : ST_DRIVE;

  // Output inversion masks applied only at the output registers.
  localparam logic [7:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_POL = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};

  // One buffer image: per-digit nibble and dot plus the leading-zero blank flag.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0]      dot;
    logic                       blz;
  } buf_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q,   idx_d;
  logic                  fs_q,    fs_d;

  buf_t                  ld_val;
  buf_t                  sh_q, sh_d;     // host-visible shadow
  buf_t                  dp_q, dp_d;     // image currently being scanned

  logic [3:0]            cur_nib;
  logic                  cur_dot;
  logic [7:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [NUM_DIGITS-1:0] dig_hot;
  logic [7:0]            seg_hi;
  logic [NUM_DIGITS-1:0] dig_hi;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] dig_q;

  assign ld_val = {bus.din, bus.dot_in, bus.blank_lz};

  // Slot timer and scan FSM: prescaler spans the whole slot, BLANK then DRIVE.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    fs_d    = 1'b0;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      presc_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = SLOT_START;
          presc_d = '0;
          idx_d   = '0;
          fs_d    = 1'b1;
        end
        ST_BLANK: begin
          presc_d = presc_q + PW'(1);
          if (presc_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            state_d = SLOT_START;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              fs_d  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Double buffer: shadow takes every load; the scanned image changes only while
  // idle or at a frame start, where a coincident load wins over the old shadow.
  always_comb begin
    sh_d = sh_q;
    dp_d = dp_q;
    if (bus.load) begin
      sh_d = ld_val;
    end
    if (bus.load && ((state_q == ST_IDLE) || fs_d)) begin
      dp_d = ld_val;
    end else if (fs_d) begin
      dp_d = sh_q;
    end
  end

  // Leading-zero mask: a digit blanks only if it and every digit above it are
  // a zero nibble without a dot; digit 0 always shows.
  always_comb begin
    logic lz_run;
    lz_mask = '0;
    lz_run  = dp_q.blz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run & (dp_q.nib[k] == 4'h0) & ~dp_q.dot[k];
      lz_mask[k] = lz_run;
    end
  end

  assign cur_nib = dp_q.nib[idx_q];
  assign cur_dot = dp_q.dot[idx_q];
  assign dig_hot = NUM_DIGITS'(1) << idx_q;

  seg7_scan_ctrl_sevendec u_dec (
    .nib_i (cur_nib),
    .dot_i (cur_dot),
    .seg_o (dec_seg)
  );

  // Active-high display value: only DRIVE lights anything.
  always_comb begin
    seg_hi = SEG_OFF;
    dig_hi = {NUM_DIGITS{DIG_OFF}};
    if (state_q == ST_DRIVE) begin
      dig_hi = dig_hot;
      if (!lz_mask[idx_q]) begin
        seg_hi = dec_seg;
      end
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      idx_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      fs_q    <= fs_d;
    end
  end

  // Shadow and scanned-image registers.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      sh_q <= '0;
      dp_q <= '0;
    end else begin
      sh_q <= sh_d;
      dp_q <= dp_d;
    end
  end

  // Output registers with polarity applied, so the pins never glitch.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      seg_q <= SEG_OFF ^ SEG_POL;
      dig_q <= {NUM_DIGITS{DIG_OFF}} ^ DIG_POL;
    end else begin
      seg_q <= seg_hi ^ SEG_POL;
      dig_q <= dig_hi ^ DIG_POL;
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.dig_sel     = dig_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 8-clock slots, 2-clock gap, active-low pins,
// plus a second instance without a blanking gap.
// Frames are captured cycle by cycle starting at a frame_start pulse.
module tb_seg7_scan_ctrl;

  logic clk;
  logic rst_x;

  int n_vec = 0;
  int n_err = 0;

  // {seg_out, dig_sel, frame_start} for offsets 1..32 after a frame_start cycle
  logic [12:0] cap [1:32];

  // Active-high codes per digit, index 3 = leftmost
  localparam logic [3:0][7:0] F_ZERO = {8'h3F, 8'h3F, 8'h3F, 8'h3F};
  localparam logic [3:0][7:0] F_1234 = {8'h06, 8'h5B, 8'h4F, 8'h66};
  localparam logic [3:0][7:0] F_ABCD = {8'h77, 8'h7C, 8'h39, 8'h5E};
  localparam logic [3:0][7:0] F_9999 = {8'h6F, 8'h6F, 8'h6F, 8'h6F};
  localparam logic [3:0][7:0] F_LZ   = {8'h00, 8'h00, 8'h6D, 8'h3F};
  localparam logic [3:0][7:0] F_LZDP = {8'hBF, 8'h3F, 8'h6D, 8'h3F};

  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) if_m  ();
  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) if_nb ();

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_dut (
    .clk   (clk),
    .rst_x (rst_x),
    .bus   (if_m.slave)
  );

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(0), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_dut_nb (
    .clk   (clk),
    .rst_x (rst_x),
    .bus   (if_nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pins at offset c of a 32-clock frame (offset 32 = next frame_start cycle).
  function automatic logic [12:0] frame_exp(input int c, input int nblank, input logic [3:0][7:0] codes);
    int slot;
    int pos;
    logic [7:0] s;
    logic [3:0] d;
    slot = (c - 1) / 8;
    pos  = (c - 1) % 8;
    if (pos < nblank) begin
      s = 8'hFF;
      d = 4'hF;
    end else begin
      s = ~codes[slot];
      d = ~(4'b0001 << slot);
    end
    return {s, d, (c == 32)};
  endfunction

  // Wait (bounded) for frame_start, then record one full frame, optionally pulsing load at offset load_c.
  task automatic capture_frame(input bit nb, input int load_c, input logic [15:0] ld_din,
                               input logic [3:0] ld_dot, input logic ld_blz);
    int n;
    n = 0;
    while (((nb ? if_nb.frame_start : if_m.frame_start) !== 1'b1) && (n < 100)) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_start_wait: got no pulse in 100 clk, required a pulse");
    end
    for (int c = 1; c <= 32; c++) begin
      if (c == load_c) begin
        if (nb) begin
          if_nb.din = ld_din; if_nb.dot_in = ld_dot; if_nb.blank_lz = ld_blz; if_nb.load = 1'b1;
        end else begin
          if_m.din = ld_din; if_m.dot_in = ld_dot; if_m.blank_lz = ld_blz; if_m.load = 1'b1;
        end
      end
      tick();
      if_m.load  = 1'b0;
      if_nb.load = 1'b0;
      cap[c] = nb ? {if_nb.seg_out, if_nb.dig_sel, if_nb.frame_start}
                  : {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    end
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst_x = 1'b0;
    repeat (3) tick();
    got = {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    n_vec++;
    if (got !== {8'hFF, 4'hF, 1'b0}) begin
      n_err++; $display("FAIL reset_hold: got %h required %h", got, {8'hFF, 4'hF, 1'b0});
    end
    rst_x = 1'b1;
    tick(); tick();
    got = {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    n_vec++;
    if (got !== {8'hFF, 4'hF, 1'b0}) begin
      n_err++; $display("FAIL idle_after_reset: got %h required %h", got, {8'hFF, 4'hF, 1'b0});
    end
    // Start scanning 1234 and reset while digit 1 is lit
    if_m.din = 16'h1234; if_m.dot_in = 4'h0; if_m.blank_lz = 1'b0; if_m.load = 1'b1;
    tick();
    if_m.load = 1'b0;
    if_m.enable = 1'b1;
    repeat (13) tick();
    got = {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    n_vec++;
    if (got !== {~8'h4F, 4'hD, 1'b0}) begin
      n_err++; $display("FAIL pre_reset_digit1: got %h required %h", got, {~8'h4F, 4'hD, 1'b0});
    end
    #2 rst_x = 1'b0;
    #1;
    got = {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    n_vec++;
    if (got !== {8'hFF, 4'hF, 1'b0}) begin
      n_err++; $display("FAIL async_reset_midscan: got %h required %h", got, {8'hFF, 4'hF, 1'b0});
    end
    tick();
    rst_x = 1'b1;
    // Reset cleared both buffers: every digit shows '0'
    capture_frame(1'b0, 0, 16'h0, 4'h0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_ZERO)) begin
        n_err++; $display("FAIL reset_cleared_display c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_ZERO));
      end
    end
    if_m.enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_scan();
    if_m.din = 16'h1234; if_m.dot_in = 4'h0; if_m.blank_lz = 1'b0; if_m.load = 1'b1;
    tick();
    if_m.load = 1'b0;
    if_m.enable = 1'b1;
    capture_frame(1'b0, 0, 16'h0, 4'h0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_1234)) begin
        n_err++; $display("FAIL scan_1234 c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_1234));
      end
    end
  endtask

  task automatic test_double_buffer();
    capture_frame(1'b0, 10, 16'hABCD, 4'h0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_1234)) begin
        n_err++; $display("FAIL shadow_hold c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_1234));
      end
    end
    capture_frame(1'b0, 0, 16'h0, 4'h0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_ABCD)) begin
        n_err++; $display("FAIL shadow_commit c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_ABCD));
      end
    end
  endtask

  task automatic test_load_on_wrap();
    capture_frame(1'b0, 32, 16'h9999, 4'h0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_ABCD)) begin
        n_err++; $display("FAIL wrap_old_frame c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_ABCD));
      end
    end
    capture_frame(1'b0, 0, 16'h0, 4'h0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_9999)) begin
        n_err++; $display("FAIL wrap_load c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_9999));
      end
    end
  endtask

  task automatic test_lead_zero();
    capture_frame(1'b0, 5, 16'h0050, 4'h0, 1'b1);
    capture_frame(1'b0, 5, 16'h0050, 4'b1000, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_LZ)) begin
        n_err++; $display("FAIL lead_zero c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_LZ));
      end
    end
    capture_frame(1'b0, 0, 16'h0, 4'h0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_LZDP)) begin
        n_err++; $display("FAIL lead_zero_dot c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_LZDP));
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [12:0] got;
    // Positioned on a frame_start cycle; offset 20 is mid-DRIVE of digit 2
    repeat (20) tick();
    got = {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    n_vec++;
    if (got !== {~8'h3F, 4'hB, 1'b0}) begin
      n_err++; $display("FAIL drive_digit2: got %h required %h", got, {~8'h3F, 4'hB, 1'b0});
    end
    if_m.enable = 1'b0;
    tick(); tick();
    got = {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    n_vec++;
    if (got !== {8'hFF, 4'hF, 1'b0}) begin
      n_err++; $display("FAIL disable_2clk: got %h required %h", got, {8'hFF, 4'hF, 1'b0});
    end
    repeat (5) tick();
    got = {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    n_vec++;
    if (got !== {8'hFF, 4'hF, 1'b0}) begin
      n_err++; $display("FAIL idle_stays_off: got %h required %h", got, {8'hFF, 4'hF, 1'b0});
    end
    if_m.enable = 1'b1;
    tick();
    got = {if_m.seg_out, if_m.dig_sel, if_m.frame_start};
    n_vec++;
    if (got !== {8'hFF, 4'hF, 1'b1}) begin
      n_err++; $display("FAIL restart_pulse: got %h required %h", got, {8'hFF, 4'hF, 1'b1});
    end
    capture_frame(1'b0, 0, 16'h0, 4'h0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      n_vec++;
      if (cap[c] !== frame_exp(c, 2, F_LZDP)) begin
        n_err++; $display("FAIL restart_frame c=%0d: got %h required %h", c, cap[c], frame_exp(c, 2, F_LZDP));
      end
    end
  endtask

  task automatic test_no_blank();
    if_nb.din = 16'h1234; if_nb.dot_in = 4'h0; if_nb.blank_lz = 1'b0; if_nb.load = 1'b1;
    tick();
    if_nb.load = 1'b0;
    if_nb.enable = 1'b1;
    for (int f = 0; f < 2; f++) begin
      capture_frame(1'b1, 0, 16'h0, 4'h0, 1'b0);
      for (int c = 1; c <= 32; c++) begin
        n_vec++;
        if (cap[c] !== frame_exp(c, 0, F_1234)) begin
          n_err++; $display("FAIL no_blank f=%0d c=%0d: got %h required %h", f, c, cap[c], frame_exp(c, 0, F_1234));
        end
      end
    end
  endtask

  initial begin
    rst_x = 1'b0;
    if_m.enable  = 1'b0; if_m.load  = 1'b0; if_m.din  = '0; if_m.dot_in  = '0; if_m.blank_lz  = 1'b0;
    if_nb.enable = 1'b0; if_nb.load = 1'b0; if_nb.din = '0; if_nb.dot_in = '0; if_nb.blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_double_buffer();
    test_load_on_wrap();
    test_lead_zero();
    test_enable_drop();
    test_no_blank();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
